vdu_write_port: RTL and testbench
=================================

// Module: vdu_write_port
// PURPOSE
// CPU-side writer for the VDU-80 character/attribute RAMs and scroll register. Buffers CPU
// stores in a small FIFO, drains them into the RAM write ports when the arbiter grants
// access, runs a hardware clear-screen fill, and publishes the scroll row to the display
// as o_counter/o_counter_valid. It is the producer end of the video RAM the display reads.
// PARAMETERS
// FIFO_DEPTH   4      write-buffer entries (power of two, >=2)
// NUM_CELLS    2048   cells cleared by a fill (full 11-bit VRAM space)
// NUM_ROWS     24     scroll counter modulus
// CLEAR_CHAR   8'h20  character written by a fill
// CLEAR_ATTR   8'h00  attribute written by a fill
// PORTS
// i_clk            in   1   system clock (same domain as display)
// i_rst            in   1   asynchronous active-high reset
// i_cpu_wr         in   1   one-cycle store strobe
// i_cpu_plane      in   1   0 = character RAM, 1 = attribute RAM
// i_cpu_addr       in   11  cell address
// i_cpu_data       in   8   store data
// i_scroll_wr      in   1   load scroll counter from i_scroll_data
// i_scroll_inc     in   1   advance scroll counter by one row
// i_scroll_data    in   5   scroll value to load
// i_clear_req      in   1   start clear-screen fill (ignored while busy clearing)
// i_grant          in   1   arbiter allows a RAM write this cycle
// o_cpu_full       out  1   FIFO full; CPU must hold off strobes
// o_busy           out  1   fill running or FIFO non-empty
// o_char_we        out  1   character RAM write enable
// o_attr_we        out  1   attribute RAM write enable
// o_waddr          out  11  RAM write address (shared by both planes)
// o_char_wdata     out  8   character write data
// o_attr_wdata     out  8   attribute write data
// o_counter        out  5   scroll row to display
// o_counter_valid  out  1   one-cycle pulse when o_counter changes
// BEHAVIOUR
// - Reset: all outputs 0, FIFO empty, state IDLE, o_counter=0. Reset mid-fill aborts it.
// - All outputs registered. Push: i_cpu_wr && !o_cpu_full stores {plane,addr,data};
//   strobe while full is dropped (CPU protocol violation, no error flag).
// - States IDLE, FILL. IDLE: if FIFO non-empty and i_grant, pop head and next cycle
//   assert exactly one of o_char_we/o_attr_we with o_waddr and the matching wdata. One
//   pop per granted cycle; push and pop in the same cycle keep occupancy unchanged.
// - Full/empty: occupancy counter 0..FIFO_DEPTH; o_cpu_full = (occupancy==FIFO_DEPTH).
//   Push accepted on the cycle a pop frees the last slot only from the next cycle.
// - IDLE->FILL on i_clear_req (priority over a pending pop that cycle). FILL: each
//   granted cycle writes CLEAR_CHAR and CLEAR_ATTR to both RAMs at fill address, then
//   increments; after address NUM_CELLS-1 return to IDLE. No write on ungranted cycles.
//   CPU pushes continue into FIFO during FILL and drain after it (so post-clear stores win).
//   i_clear_req during FILL ignored. Fill address counter is 11 bits, wrap not reached.
// - Scroll: i_scroll_wr loads i_scroll_data (values >=NUM_ROWS reduced to 0);
//   i_scroll_inc adds 1 with wrap NUM_ROWS-1 -> 0; both same cycle: load wins. Result
//   appears on o_counter one cycle later with o_counter_valid high for that cycle.
//   Scroll updates are independent of FIFO/FILL state.
// - o_busy = (state==FILL) || occupancy!=0; write-enable latency from grant = 1 cycle.
// TESTING
// - Reset, push char (addr 0x050, 0x41), i_grant=1 -> 2 cycles later o_char_we=1, o_waddr=0x050, data 0x41.
// - i_grant=0, push 5 stores -> o_cpu_full after 4th, 5th dropped; grant -> exactly 4 writes in order.
// - i_clear_req with grant held -> 2048 cycles of both WEs, addr 0..0x7FF, 0x20/0x00, then IDLE.
// - Push attr (0x010,0x08) mid-fill -> written after fill's last address, o_busy low after.
// - Scroll load 23 then inc -> o_counter 23 then 0, each with a 1-cycle o_counter_valid.
// - Assert i_rst mid-fill at addr 0x100 -> WEs drop immediately, FIFO empty, o_counter=0.

Source files
------------

// File: rtl/vdu_write_port_if.sv
// vdu_write_port_if: CPU store, scroll, clear, arbiter grant and VRAM write bus of the VDU-80 writer
//   master : drives i_cpu_*, i_scroll_*, i_clear_req, i_grant; observes the o_* signals
//   slave  : the write port itself; drives o_cpu_full, o_busy, o_*_we, o_waddr,
//            o_*_wdata, o_counter, o_counter_valid
interface vdu_write_port_if;
   logic        i_cpu_wr;
   logic        i_cpu_plane;
   logic [10:0] i_cpu_addr;
   logic [7:0]  i_cpu_data;
   logic        i_scroll_wr;
   logic        i_scroll_inc;
   logic [4:0]  i_scroll_data;
   logic        i_clear_req;
   logic        i_grant;
   logic        o_cpu_full;
   logic        o_busy;
   logic        o_char_we;
   logic        o_attr_we;
   logic [10:0] o_waddr;
   logic [7:0]  o_char_wdata;
   logic [7:0]  o_attr_wdata;
   logic [4:0]  o_counter;
   logic        o_counter_valid;
   modport master (
      output i_cpu_wr, i_cpu_plane, i_cpu_addr, i_cpu_data, i_scroll_wr, i_scroll_inc,
             i_scroll_data, i_clear_req, i_grant,
      input  o_cpu_full, o_busy, o_char_we, o_attr_we, o_waddr, o_char_wdata, o_attr_wdata,
             o_counter, o_counter_valid
   );
   modport slave (
      input  i_cpu_wr, i_cpu_plane, i_cpu_addr, i_cpu_data, i_scroll_wr, i_scroll_inc,
             i_scroll_data, i_clear_req, i_grant,
      output o_cpu_full, o_busy, o_char_we, o_attr_we, o_waddr, o_char_wdata, o_attr_wdata,
             o_counter, o_counter_valid
   );
endinterface

// File: rtl/vdu_write_port.sv
// vdu_write_port: buffers CPU stores into the VDU-80 char/attr RAMs, runs clear-screen fills, publishes the scroll row
//   i_clk, i_rst : clock and asynchronous active-high reset
//   bus (slave)  : CPU store strobe/plane/addr/data, scroll load/inc/data, clear request,
//                  arbiter grant in; FIFO full, busy, RAM write enables/address/data,
//                  scroll counter and its one-cycle valid pulse out (all registered)
module vdu_write_port #(
   parameter int         FIFO_DEPTH = 4,
   parameter int         NUM_CELLS  = 2048,
   parameter int         NUM_ROWS   = 24,
   parameter logic [7:0] CLEAR_CHAR = 8'h20,
   parameter logic [7:0] CLEAR_ATTR = 8'h00
) (
   input logic             i_clk,
   input logic             i_rst,
   vdu_write_port_if.slave bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] FILL = 1'b1;
   logic [0:0]    state, state_next;
   logic [19:0]   mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count, count_next;
   logic [10:0]   fill_addr;
   logic [19:0]   head;
   logic [4:0]    scroll_next;
   logic          push, pop, start_fill, fill_wr, scroll_upd;
   // o_cpu_full mirrors count==FIFO_DEPTH, so a slot freed by a pop is usable next cycle
   assign push       = bus.i_cpu_wr && !bus.o_cpu_full;
   assign start_fill = state == IDLE && bus.i_clear_req;
   assign pop        = state == IDLE && !bus.i_clear_req && count != '0 && bus.i_grant;
   assign fill_wr    = state == FILL && bus.i_grant;
   assign head       = mem[rd_ptr];
   assign scroll_upd = bus.i_scroll_wr || bus.i_scroll_inc;
   always_comb begin
      count_next  = count + CW'(push) - CW'(pop);
      state_next  = start_fill ? FILL :
                    (fill_wr && fill_addr == 11'(NUM_CELLS - 1)) ? IDLE : state;
      scroll_next = bus.i_scroll_wr ?
                    (({27'd0, bus.i_scroll_data} >= 32'(NUM_ROWS)) ? 5'd0 : bus.i_scroll_data) :
                    (bus.o_counter == 5'(NUM_ROWS - 1)) ? 5'd0 : bus.o_counter + 5'd1;
   end
   // entry layout: {plane, addr[10:0], data[7:0]}
   always_ff @(posedge i_clk)
      if (push) mem[wr_ptr] <= {bus.i_cpu_plane, bus.i_cpu_addr, bus.i_cpu_data};
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         state               <= IDLE;
         wr_ptr              <= '0;
         rd_ptr              <= '0;
         count               <= '0;
         fill_addr           <= '0;
         bus.o_cpu_full      <= 1'b0;
         bus.o_busy          <= 1'b0;
         bus.o_char_we       <= 1'b0;
         bus.o_attr_we       <= 1'b0;
         bus.o_waddr         <= '0;
         bus.o_char_wdata    <= '0;
         bus.o_attr_wdata    <= '0;
         bus.o_counter       <= '0;
         bus.o_counter_valid <= 1'b0;
      end else begin
         state          <= state_next;
         count          <= count_next;
         bus.o_cpu_full <= count_next == CW'(FIFO_DEPTH);
         bus.o_busy     <= state_next == FILL || count_next != '0;
         wr_ptr         <= push ? wr_ptr + PW'(1) : wr_ptr;
         rd_ptr         <= pop ? rd_ptr + PW'(1) : rd_ptr;
         fill_addr      <= start_fill ? 11'd0 : fill_wr ? fill_addr + 11'd1 : fill_addr;
         bus.o_char_we  <= fill_wr || (pop && !head[19]);
         bus.o_attr_we  <= fill_wr || (pop && head[19]);
         if (fill_wr) begin
            bus.o_waddr      <= fill_addr;
            bus.o_char_wdata <= CLEAR_CHAR;
            bus.o_attr_wdata <= CLEAR_ATTR;
         end else if (pop) begin
            bus.o_waddr <= head[18:8];
            if (head[19]) bus.o_attr_wdata <= head[7:0];
            else bus.o_char_wdata <= head[7:0];
         end
         bus.o_counter_valid <= scroll_upd;
         if (scroll_upd) bus.o_counter <= scroll_next;
      end
endmodule

// File: tb/tb_vdu_write_port.sv
// tb_vdu_write_port: scoreboard bench for vdu_write_port (expected RAM writes and scroll values queued, monitor compares)
module tb_vdu_write_port;
   typedef struct {
      logic        cw;
      logic        aw;
      logic [10:0] a;
      logic [7:0]  cd;
      logic [7:0]  ad;
   } wr_t;
   logic i_clk, i_rst;
   vdu_write_port_if bus();
   vdu_write_port dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));
   wr_t wq[$];
   int  sq[$];
   int  n_cmp, n_err;
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;
   initial begin
      #400000;
      $display("FAIL timeout reached before summary");
      $fatal(1, "timeout");
   end
   task automatic cycle();
      @(posedge i_clk);
      #1;
   endtask
   task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask
   function automatic void exp_cpu(logic p, logic [10:0] addr, logic [7:0] d);
      wq.push_back('{!p, p, addr, d, d});
   endfunction
   task automatic store(logic p, logic [10:0] addr, logic [7:0] d);
      bus.i_cpu_wr    = 1'b1;
      bus.i_cpu_plane = p;
      bus.i_cpu_addr  = addr;
      bus.i_cpu_data  = d;
      cycle();
      bus.i_cpu_wr = 1'b0;
   endtask
   task automatic scroll(logic wr, logic inc, logic [4:0] d, int exp);
      sq.push_back(exp);
      bus.i_scroll_wr   = wr;
      bus.i_scroll_inc  = inc;
      bus.i_scroll_data = d;
      cycle();
      bus.i_scroll_wr  = 1'b0;
      bus.i_scroll_inc = 1'b0;
      chk("scroll_counter", 32'(bus.o_counter), 32'(exp));
      chk("scroll_valid", 32'(bus.o_counter_valid), 32'd1);
   endtask
   task automatic monitor();
      wr_t e;
      int  s;
      forever begin
         @(negedge i_clk);
         if (!i_rst && (bus.o_char_we || bus.o_attr_we)) begin
            n_cmp++;
            if (wq.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_write we=%b%b addr=%h", bus.o_char_we, bus.o_attr_we, bus.o_waddr);
            end else begin
               e = wq.pop_front();
               if (bus.o_char_we !== e.cw || bus.o_attr_we !== e.aw || bus.o_waddr !== e.a ||
                   (e.cw && bus.o_char_wdata !== e.cd) || (e.aw && bus.o_attr_wdata !== e.ad)) begin
                  n_err++;
                  $display("FAIL ram_write got we=%b%b addr=%h c=%h a=%h expected we=%b%b addr=%h c=%h a=%h",
                           bus.o_char_we, bus.o_attr_we, bus.o_waddr, bus.o_char_wdata, bus.o_attr_wdata,
                           e.cw, e.aw, e.a, e.cd, e.ad);
               end
            end
         end
         if (!i_rst && bus.o_counter_valid) begin
            n_cmp++;
            if (sq.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_counter_valid counter=%0d", bus.o_counter);
            end else begin
               s = sq.pop_front();
               if (32'(bus.o_counter) !== 32'(s)) begin
                  n_err++;
                  $display("FAIL counter_pulse got=%0d expected=%0d", bus.o_counter, s);
               end
            end
         end
      end
   endtask
   initial begin
      int  n;
      logic found;
      i_rst             = 1'b1;
      bus.i_cpu_wr      = 1'b0;
      bus.i_cpu_plane   = 1'b0;
      bus.i_cpu_addr    = '0;
      bus.i_cpu_data    = '0;
      bus.i_scroll_wr   = 1'b0;
      bus.i_scroll_inc  = 1'b0;
      bus.i_scroll_data = '0;
      bus.i_clear_req   = 1'b0;
      bus.i_grant       = 1'b0;
      fork
         monitor();
      join_none
      repeat (2) cycle();
      chk("rst_char_we", 32'(bus.o_char_we), 32'd0);
      chk("rst_attr_we", 32'(bus.o_attr_we), 32'd0);
      chk("rst_waddr", 32'(bus.o_waddr), 32'd0);
      chk("rst_full", 32'(bus.o_cpu_full), 32'd0);
      chk("rst_busy", 32'(bus.o_busy), 32'd0);
      chk("rst_counter", 32'(bus.o_counter), 32'd0);
      chk("rst_counter_valid", 32'(bus.o_counter_valid), 32'd0);
      i_rst = 1'b0;
      cycle();
      // single char store, write enable two edges after the strobe
      bus.i_grant = 1'b1;
      exp_cpu(1'b0, 11'h050, 8'h41);
      store(1'b0, 11'h050, 8'h41);
      chk("lat_first_edge_we", 32'(bus.o_char_we), 32'd0);
      cycle();
      chk("lat_second_edge_we", 32'(bus.o_char_we), 32'd1);
      chk("lat_waddr", 32'(bus.o_waddr), 32'h050);
      chk("lat_wdata", 32'(bus.o_char_wdata), 32'h41);
      cycle();
      chk("single_busy_clear", 32'(bus.o_busy), 32'd0);
      // fill the FIFO without grant, fifth store dropped
      bus.i_grant = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i < 4) exp_cpu(i[0], 11'(256 + i), 8'(16 + i));
         store(i[0], 11'(256 + i), 8'(16 + i));
         if (i == 2) chk("full_at_3", 32'(bus.o_cpu_full), 32'd0);
         if (i >= 3) chk("full_at_4", 32'(bus.o_cpu_full), 32'd1);
      end
      chk("busy_fifo", 32'(bus.o_busy), 32'd1);
      chk("no_write_ungranted", 32'(bus.o_char_we | bus.o_attr_we), 32'd0);
      bus.i_grant = 1'b1;
      cycle();
      chk("full_release", 32'(bus.o_cpu_full), 32'd0);
      repeat (6) cycle();
      chk("drain_busy", 32'(bus.o_busy), 32'd0);
      chk("drain_queue", 32'(wq.size()), 32'd0);
      // clear-screen fill with an ungranted gap, an ignored re-request and a mid-fill store
      for (int i = 0; i < 2048; i++) wq.push_back('{1'b1, 1'b1, 11'(i), 8'h20, 8'h00});
      bus.i_clear_req = 1'b1;
      cycle();
      bus.i_clear_req = 1'b0;
      chk("fill_busy", 32'(bus.o_busy), 32'd1);
      repeat (10) cycle();
      bus.i_grant = 1'b0;
      repeat (5) cycle();
      chk("fill_gap_no_we", 32'(bus.o_char_we | bus.o_attr_we), 32'd0);
      bus.i_grant     = 1'b1;
      bus.i_clear_req = 1'b1;
      exp_cpu(1'b1, 11'h010, 8'h08);
      store(1'b1, 11'h010, 8'h08);
      bus.i_clear_req = 1'b0;
      n = 0;
      while (bus.o_busy && n < 2300) begin
         cycle();
         n++;
      end
      chk("fill_done_busy", 32'(bus.o_busy), 32'd0);
      repeat (4) cycle();
      chk("fill_queue_drained", 32'(wq.size()), 32'd0);
      // scroll counter
      scroll(1'b1, 1'b0, 5'd23, 23);
      scroll(1'b0, 1'b1, 5'd0, 0);
      cycle();
      chk("scroll_pulse_end", 32'(bus.o_counter_valid), 32'd0);
      scroll(1'b1, 1'b0, 5'd30, 0);
      scroll(1'b1, 1'b1, 5'd5, 5);
      scroll(1'b0, 1'b1, 5'd0, 6);
      cycle();
      chk("scroll_queue", 32'(sq.size()), 32'd0);
      // reset in the middle of a fill
      for (int i = 0; i < 256; i++) wq.push_back('{1'b1, 1'b1, 11'(i), 8'h20, 8'h00});
      bus.i_clear_req = 1'b1;
      cycle();
      bus.i_clear_req = 1'b0;
      store(1'b0, 11'h003, 8'h55);
      found = 1'b0;
      for (int i = 0; i < 400; i++) begin
         cycle();
         if (bus.o_char_we && bus.o_waddr == 11'h100) begin
            found = 1'b1;
            break;
         end
      end
      chk("fill_reach_100", 32'(found), 32'd1);
      #1 i_rst = 1'b1;
      #1;
      chk("abort_char_we", 32'(bus.o_char_we), 32'd0);
      chk("abort_attr_we", 32'(bus.o_attr_we), 32'd0);
      chk("abort_busy", 32'(bus.o_busy), 32'd0);
      chk("abort_full", 32'(bus.o_cpu_full), 32'd0);
      chk("abort_counter", 32'(bus.o_counter), 32'd0);
      chk("abort_queue", 32'(wq.size()), 32'd0);
      repeat (2) cycle();
      i_rst = 1'b0;
      repeat (10) cycle();
      chk("post_reset_busy", 32'(bus.o_busy), 32'd0);
      chk("final_queue", 32'(wq.size() + sq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
